fix_checksum_ctrl: RTL and testbench

Frames the incoming FIX byte stream and sequences checksum verification for each message. It finds the `8=` header and accumulates the running modulo-256 sum. It detects the `<SOH>10=` trailer tag, decodes the three ASCII checksum digits and issues a verdict. It sits between the byte receiver and the field parser, and gives the parser message-boundary strobes plus an accept/reject result per message.

---
 rtl/fix_checksum_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fix_checksum_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fix_checksum_ctrl.sv
// FIX message framer: finds the 8= header, sums the message modulo 256, decodes the
// 10=nnn trailer and reports a per-message checksum verdict plus saturating statistics.
module fix_checksum_ctrl #(
    parameter int unsigned MAX_LEN = 4096,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_i,
    input  logic             data_valid_i,
    input  logic             clr_cnt_i,
    output logic             msg_start_o,
    output logic             msg_end_o,
    output logic             done_o,
    output logic             chk_ok_o,
    output logic             frame_err_o,
    output logic [7:0]       computed_o,
    output logic [7:0]       received_o,
    output logic [CNT_W-1:0] ok_cnt_o,
    output logic [CNT_W-1:0] bad_cnt_o
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] BODY = 3'd2;
    localparam logic [2:0] T1   = 3'd3;
    localparam logic [2:0] T2   = 3'd4;
    localparam logic [2:0] T3   = 3'd5;
    localparam logic [2:0] DIG  = 3'd6;
    localparam logic [2:0] TERM = 3'd7;

    localparam logic [7:0] CH_SOH = 8'h01;
    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_1   = 8'h31;
    localparam logic [7:0] CH_8   = 8'h38;
    localparam logic [7:0] CH_EQ  = 8'h3D;

    logic [2:0]       state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       comp_q, comp_d;
    logic [9:0]       val_q, val_d;
    logic [1:0]       dcnt_q, dcnt_d;
    logic             start_q, start_d;
    logic             end_q, end_d;
    logic             ferr_q, ferr_d;
    logic             done_q, chk_ok_q;
    logic [7:0]       computed_q, received_q;
    logic [CNT_W-1:0] ok_cnt_q, bad_cnt_q;

    logic             is_digit;
    logic [7:0]       sum_add;
    logic [LEN_W-1:0] len_inc;
    logic             len_hit;
    logic             verdict;

    assign is_digit = (data_i >= CH_0) && (data_i <= 8'h39);
    assign sum_add  = sum_q + data_i;
    assign len_inc  = len_q + 1'b1;
    assign len_hit  = (len_inc == LEN_W'(MAX_LEN));
    assign verdict  = (val_q <= 10'd255) && (val_q[7:0] == comp_q);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        len_d   = len_q;
        comp_d  = comp_q;
        val_d   = val_q;
        dcnt_d  = dcnt_q;
        start_d = 1'b0;
        end_d   = 1'b0;
        ferr_d  = 1'b0;
        if (data_valid_i) begin
            case (state_q)
                IDLE: if (data_i == CH_8) state_d = HDR;
                HDR: begin
                    if (data_i == CH_EQ) begin
                        state_d = BODY;
                        sum_d   = 8'h75;  // '8' + '=' already seen
                        len_d   = '0;
                        start_d = 1'b1;
                    end else if (data_i != CH_8) begin
                        state_d = IDLE;
                    end
                end
                BODY, T1, T2, T3: begin
                    if (state_q == T3 && data_i == CH_EQ) begin
                        state_d = DIG;
                        comp_d  = sum_q - (CH_1 + CH_0);  // drop the "10" of the tag
                        val_d   = '0;
                        dcnt_d  = '0;
                    end else begin
                        sum_d = sum_add;
                        len_d = len_inc;
                        if (len_hit) begin
                            state_d = IDLE;
                            ferr_d  = 1'b1;
                        end else if (data_i == CH_SOH) begin
                            state_d = T1;
                        end else if (state_q == T1 && data_i == CH_1) begin
                            state_d = T2;
                        end else if (state_q == T2 && data_i == CH_0) begin
                            state_d = T3;
                        end else begin
                            state_d = BODY;
                        end
                    end
                end
                DIG: begin
                    if (is_digit) begin
                        val_d  = val_q * 10'd10 + {2'b00, data_i - CH_0};
                        dcnt_d = dcnt_q + 2'd1;
                        if (dcnt_q == 2'd2) state_d = TERM;
                    end else begin
                        state_d = IDLE;
                        ferr_d  = 1'b1;
                    end
                end
                TERM: begin
                    state_d = IDLE;
                    if (data_i == CH_SOH) end_d = 1'b1;
                    else                  ferr_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            len_q      <= '0;
            comp_q     <= '0;
            val_q      <= '0;
            dcnt_q     <= '0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
            chk_ok_q   <= 1'b0;
            computed_q <= '0;
            received_q <= '0;
            ok_cnt_q   <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            len_q   <= len_d;
            comp_q  <= comp_d;
            val_q   <= val_d;
            dcnt_q  <= dcnt_d;
            start_q <= start_d;
            end_q   <= end_d;
            ferr_q  <= ferr_d;
            // Verdict resolves the cycle after msg_end; comp_q/val_q cannot change before then.
            done_q  <= end_q;
            if (end_q) begin
                chk_ok_q   <= verdict;
                computed_q <= comp_q;
                received_q <= val_q[7:0];
            end
            if (clr_cnt_i) begin
                ok_cnt_q  <= '0;
                bad_cnt_q <= '0;
            end else if (end_q) begin
                if (verdict && ok_cnt_q != {CNT_W{1'b1}}) ok_cnt_q <= ok_cnt_q + 1'b1;
                if (!verdict && bad_cnt_q != {CNT_W{1'b1}}) bad_cnt_q <= bad_cnt_q + 1'b1;
            end
        end
    end

    assign msg_start_o = start_q;
    assign msg_end_o   = end_q;
    assign frame_err_o = ferr_q;
    assign done_o      = done_q;
    assign chk_ok_o    = chk_ok_q;
    assign computed_o  = computed_q;
    assign received_o  = received_q;
    assign ok_cnt_o    = ok_cnt_q;
    assign bad_cnt_o   = bad_cnt_q;

endmodule

// File: tb/tb_fix_checksum_ctrl.sv
// Scoreboard bench for fix_checksum_ctrl: stimulus pushes expected pulses/verdicts into
// queues, a negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_fix_checksum_ctrl;

    localparam int CNT_W = 16;

    typedef struct {
        logic        chk;
        logic [7:0]  comp;
        logic [7:0]  rcv;
        int          okc;
        int          badc;
    } done_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       data_i;
    logic             data_valid_i;
    logic             clr_cnt_i;
    logic             msg_start_o, msg_end_o, done_o, chk_ok_o, frame_err_o;
    logic [7:0]       computed_o, received_o;
    logic [CNT_W-1:0] ok_cnt_o, bad_cnt_o;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    q_start[$];
    int    q_end[$];
    int    q_ferr[$];
    done_t q_done[$];
    int    m_ok = 0;
    int    m_bad = 0;
    bit    gap = 1'b0;

    fix_checksum_ctrl #(.MAX_LEN(8), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .clr_cnt_i    (clr_cnt_i),
        .msg_start_o  (msg_start_o),
        .msg_end_o    (msg_end_o),
        .done_o       (done_o),
        .chk_ok_o     (chk_ok_o),
        .frame_err_o  (frame_err_o),
        .computed_o   (computed_o),
        .received_o   (received_o),
        .ok_cnt_o     (ok_cnt_o),
        .bad_cnt_o    (bad_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_pulse(input string name, inout int q[$]);
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got unexpected pulse, required none", name);
        end else begin
            void'(q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (msg_start_o) pop_pulse("msg_start", q_start);
        if (msg_end_o)   pop_pulse("msg_end", q_end);
        if (frame_err_o) pop_pulse("frame_err", q_ferr);
        if (done_o) begin
            if (q_done.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done: got unexpected pulse, required none");
            end else begin
                done_t e;
                e = q_done.pop_front();
                check("chk_ok", int'(chk_ok_o), int'(e.chk));
                check("computed", int'(computed_o), int'(e.comp));
                check("received", int'(received_o), int'(e.rcv));
                check("ok_cnt", int'(ok_cnt_o), e.okc);
                check("bad_cnt", int'(bad_cnt_o), e.badc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        data_i       = b;
        data_valid_i = 1'b1;
        @(posedge clk);
        #1;
        data_valid_i = 1'b0;
        data_i       = 8'hFF;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // '|' stands for SOH
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte((s[i] == "|") ? 8'h01 : s[i]);
        end
    endtask

    task automatic expect_msg(input logic chk, input logic [7:0] comp, input logic [7:0] rcv,
                              input bit clr);
        done_t e;
        if (clr) begin
            m_ok  = 0;
            m_bad = 0;
        end else if (chk) begin
            m_ok++;
        end else begin
            m_bad++;
        end
        e.chk  = chk;
        e.comp = comp;
        e.rcv  = rcv;
        e.okc  = m_ok;
        e.badc = m_bad;
        q_start.push_back(1);
        q_end.push_back(1);
        q_done.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst msg_start", int'(msg_start_o), 0);
        check("rst msg_end", int'(msg_end_o), 0);
        check("rst done", int'(done_o), 0);
        check("rst frame_err", int'(frame_err_o), 0);
        check("rst chk_ok", int'(chk_ok_o), 0);
        check("rst computed", int'(computed_o), 0);
        check("rst received", int'(received_o), 0);
        check("rst ok_cnt", int'(ok_cnt_o), 0);
        check("rst bad_cnt", int'(bad_cnt_o), 0);
    endtask

    initial begin
        rst          = 1'b1;
        data_i       = 8'h00;
        data_valid_i = 1'b0;
        clr_cnt_i    = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);
        check_reset_vals();

        // 0x75+'A'+SOH+'1'+'0' - 0x61 = 0xB7
        expect_msg(1'b1, 8'hB7, 8'hB7, 1'b0);
        send_str("8=A|10=183|");
        idle(4);
        expect_msg(1'b0, 8'hB7, 8'hB8, 1'b0);
        send_str("8=A|10=184|");
        idle(4);
        // "1A" after SOH is a false tag and stays in the sum
        expect_msg(1'b1, 8'hE9, 8'hE9, 1'b0);
        send_str("8=|1A|10=233|");
        idle(4);
        expect_msg(1'b0, 8'hB7, 8'h00, 1'b0);
        send_str("8=A|10=256|");
        idle(4);

        q_start.push_back(1);
        q_ferr.push_back(1);
        send_str("8=A|10=1X3|");
        idle(4);

        // MAX_LEN=8: error on 8th body byte, 9th byte ignored in IDLE
        q_start.push_back(1);
        q_ferr.push_back(1);
        send_str("8=ABCDEFGHI");
        idle(4);
        expect_msg(1'b1, 8'hB7, 8'hB7, 1'b0);
        send_str("8=A|10=183|");
        idle(4);

        gap = 1'b1;
        expect_msg(1'b1, 8'hB7, 8'hB7, 1'b0);
        send_str("8=A|10=183|");
        gap = 1'b0;
        idle(4);

        expect_msg(1'b1, 8'hB7, 8'hB7, 1'b0);
        expect_msg(1'b0, 8'hB7, 8'hB8, 1'b0);
        send_str("8=A|10=183|8=A|10=184|");
        idle(4);

        // clear overlapping the counter update
        expect_msg(1'b1, 8'hB7, 8'hB7, 1'b1);
        send_str("8=A|10=183|");
        clr_cnt_i = 1'b1;
        idle(2);
        clr_cnt_i = 1'b0;
        idle(3);
        expect_msg(1'b0, 8'hE9, 8'hB7, 1'b0);
        send_str("8=|1A|10=183|");
        idle(4);

        // reset mid-body: only the already-issued start pulse is expected
        q_start.push_back(1);
        send_str("8=AB|1");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_ok  = 0;
        m_bad = 0;
        check_reset_vals();
        send_str("0=183|");
        idle(3);
        expect_msg(1'b1, 8'hB7, 8'hB7, 1'b0);
        send_str("8=A|10=183|");

        for (int i = 0; i < 200; i++) begin
            if (q_start.size() == 0 && q_end.size() == 0 && q_ferr.size() == 0
                && q_done.size() == 0) break;
            idle(1);
        end
        idle(5);
        check("pending msg_start", q_start.size(), 0);
        check("pending msg_end", q_end.size(), 0);
        check("pending frame_err", q_ferr.size(), 0);
        check("pending done", q_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
